// File: rtl/apb_pkg.sv
// Shared APB types: request/response payloads, bus widths and the master bridge FSM states.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = APB_DATA_W / 8;
  localparam int APB_PROT_W = 3;

  localparam int unsigned APB_MASTER_TIMEOUT_DEFAULT = 16;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic                  write;
    logic [APB_STRB_W-1:0] strb;
    logic [APB_PROT_W-1:0] prot;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  slverr;
  } apb_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_master_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// Request channel to APB3/4 master, one transfer outstanding; APB_MASTER_TIMEOUT_EN adds an ACCESS wait limit.
// Latency: accept at cycle 0, SETUP 1, ACCESS 2, resp_valid 3 with no wait states (4 cycles per transfer minimum).
// Backpressure: resp_ready low parks the FSM in RESP with the APB bus idle and no new request accepted.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = APB_MASTER_TIMEOUT_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  apb_req_t              req_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output apb_resp_t             resp_o,
  output logic [APB_ADDR_W-1:0] paddr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [APB_DATA_W-1:0] pwdata_o,
  output logic [APB_STRB_W-1:0] pstrb_o,
  output logic [APB_PROT_W-1:0] pprot_o,
  input  logic [APB_DATA_W-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  apb_master_state_e state_q, state_d;
  apb_req_t          req_q;
  apb_resp_t         resp_q, resp_d;
  logic              ready_q;
  logic              accept;
  logic              timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      wait_cnt_q <= '0;
    end else if (state_q == ACCESS && !pready_i) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign timeout = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Ready is a flop so it reads 0 through reset and only rises on the first edge after release.
  assign accept = req_valid_i && ready_q && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          resp_d.rdata  = req_q.write ? '0 : prdata_i;
          resp_d.slverr = pslverr_i;
          state_d       = RESP;
        end else if (timeout) begin
          resp_d.rdata  = '0;
          resp_d.slverr = 1'b1;
          state_d       = RESP;
        end
      end
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      resp_q  <= resp_d;
      if (accept) req_q <= req_i;
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = (state_q == RESP);
  assign resp_o       = resp_q;
  assign psel_o       = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o    = (state_q == ACCESS);
  assign paddr_o      = req_q.addr;
  assign pwrite_o     = req_q.write;
  assign pwdata_o     = req_q.wdata;
  assign pstrb_o      = req_q.strb;
  assign pprot_o      = req_q.prot;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge; timeout cases build only with APB_MASTER_TIMEOUT_EN.
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  apb_req_t    req_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  apb_resp_t   resp_o;
  logic [31:0] paddr_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [2:0]  pprot_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  int n_chk  = 0;
  int n_fail = 0;

  apb_master_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_o(resp_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pprot_o(pprot_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] addr, input logic [31:0] wdata, input logic write,
                      input logic [3:0] strb, input logic [2:0] prot);
    req_i.addr  = addr;
    req_i.wdata = wdata;
    req_i.write = write;
    req_i.strb  = strb;
    req_i.prot  = prot;
    req_valid_i = 1'b1;
  endtask

  logic [31:0] b2b_addr [3];
  int          exp_acc  [3];
  int          n_acc;
  int          psel_bad;
  logic        prev_hs;

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; req_i = '0; resp_ready_i = 1'b1;
    prdata_i = '0; pready_i = 1'b1; pslverr_i = 1'b0;
    b2b_addr = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300};
    exp_acc  = '{0, 4, 8};

    // Reset state
    #12;
    check_val("rst_outputs", {req_ready_o, resp_valid_o, psel_o, penable_o, pwrite_o},
              5'b0);
    check_val("rst_bus", {paddr_o, pwdata_o, pstrb_o, pprot_o, resp_o}, '0);
    #10 rst_ni = 1'b1;
    tick();
    check_val("ready_after_rst", req_ready_o, 1'b1);

    // Write, no wait states
    send(32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 4'hF, 3'b010);
    tick();
    req_valid_i = 1'b0;
    check_val("wr_c1_sel_en", {psel_o, penable_o, req_ready_o}, 3'b100);
    check_val("wr_c1_bus", {paddr_o, pwdata_o, pwrite_o, pstrb_o, pprot_o},
              {32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 4'hF, 3'b010});
    tick();
    check_val("wr_c2_sel_en", {psel_o, penable_o, resp_valid_o}, 3'b110);
    check_val("wr_c2_bus", {paddr_o, pwdata_o}, {32'h0000_1000, 32'hDEAD_BEEF});
    tick();
    check_val("wr_c3_resp", {resp_valid_o, psel_o, penable_o, resp_o}, {3'b100, 32'h0, 1'b0});
    tick();
    check_val("wr_c4_idle", {resp_valid_o, req_ready_o}, 2'b01);

    // Read with 3 wait states
    pready_i = 1'b0;
    send(32'h0000_2004, 32'h0, 1'b0, 4'h0, 3'b000);
    for (int c = 1; c <= 5; c++) begin
      tick();
      req_valid_i = 1'b0;
      check_val($sformatf("rd_ready_c%0d", c), req_ready_o, 1'b0);
      if (c == 5) begin
        check_val("rd_c5_access", {psel_o, penable_o, resp_valid_o}, 3'b110);
        pready_i = 1'b1;
        prdata_i = 32'h1234_5678;
      end
    end
    tick();
    check_val("rd_c6_resp", {resp_valid_o, req_ready_o, resp_o}, {2'b10, 32'h1234_5678, 1'b0});
    tick();
    check_val("rd_c7_idle", {resp_valid_o, req_ready_o}, 2'b01);

    // Read with slave error and response backpressure, second request pending
    prdata_i = 32'hCAFE_F00D; pslverr_i = 1'b1; resp_ready_i = 1'b0;
    send(32'h0000_2008, 32'h0, 1'b0, 4'h0, 3'b001);
    tick();
    send(32'h0000_3000, 32'h5555_AAAA, 1'b1, 4'h3, 3'b000);
    tick();
    tick();
    pslverr_i = 1'b0; prdata_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("err_hold%0d", i),
                {resp_valid_o, psel_o, penable_o, req_ready_o, resp_o},
                {4'b1000, 32'hCAFE_F00D, 1'b1});
      if (i < 4) tick();
    end
    resp_ready_i = 1'b1;
    tick();
    check_val("err_idle", {resp_valid_o, req_ready_o, psel_o}, 3'b010);
    tick();
    req_valid_i = 1'b0;
    check_val("pend_setup", {psel_o, penable_o, paddr_o, pwdata_o},
              {2'b10, 32'h0000_3000, 32'h5555_AAAA});
    tick();
    tick();
    check_val("pend_resp", {resp_valid_o, resp_o}, {1'b1, 32'h0, 1'b0});
    tick();

    // Back-to-back writes with req_valid held high
    n_acc = 0; psel_bad = 0; prev_hs = 1'b0;
    send(b2b_addr[0], 32'h1111_0000, 1'b1, 4'hF, 3'b000);
    for (int cyc = 0; cyc < 13; cyc++) begin
      if (prev_hs) begin
        check_val($sformatf("b2b_addr%0d", n_acc - 1), paddr_o, {32'h0, b2b_addr[n_acc-1]});
        if (n_acc < 3) send(b2b_addr[n_acc], 32'h1111_0000 + n_acc, 1'b1, 4'hF, 3'b000);
        else req_valid_i = 1'b0;
        prev_hs = 1'b0;
      end
      if (req_valid_i && req_ready_o) begin
        if (n_acc < 3) check_val($sformatf("b2b_acc%0d", n_acc), cyc, exp_acc[n_acc]);
        n_acc++;
        prev_hs = 1'b1;
      end
      if (psel_o && (resp_valid_o || req_ready_o)) psel_bad++;
      tick();
    end
    check_val("b2b_count", n_acc, 3);
    check_val("b2b_psel_idle", psel_bad, 0);

    // Reset during a waited ACCESS, then a fresh read
    pready_i = 1'b0;
    send(32'h0000_4000, 32'h0, 1'b0, 4'h0, 3'b000);
    tick();
    req_valid_i = 1'b0;
    tick();
    tick();
    check_val("pre_rst_access", {psel_o, penable_o}, 2'b11);
    #2 rst_ni = 1'b0;
    #1;
    check_val("mid_rst", {psel_o, penable_o, resp_valid_o, req_ready_o}, 4'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check_val("post_rst_ready", req_ready_o, 1'b1);
    pready_i = 1'b1; prdata_i = 32'h0BAD_CAFE;
    send(32'h0000_4004, 32'h0, 1'b0, 4'h0, 3'b000);
    tick();
    req_valid_i = 1'b0;
    check_val("fresh_setup_addr", paddr_o, 32'h0000_4004);
    tick();
    tick();
    check_val("fresh_resp", {resp_valid_o, resp_o}, {1'b1, 32'h0BAD_CAFE, 1'b0});
    tick();

`ifdef APB_MASTER_TIMEOUT_EN
    // Timeout after the 16th wait cycle
    pready_i = 1'b0; prdata_i = 32'hFFFF_FFFF;
    send(32'h0000_5000, 32'h0, 1'b0, 4'h0, 3'b000);
    tick();
    req_valid_i = 1'b0;
    for (int c = 2; c <= 17; c++) tick();
    check_val("to_c17_access", {psel_o, penable_o, resp_valid_o}, 3'b110);
    tick();
    check_val("to_resp", {resp_valid_o, psel_o, penable_o, resp_o}, {3'b100, 32'h0, 1'b1});
    tick();
    // pready on the 16th cycle wins over the timeout
    send(32'h0000_5004, 32'h0, 1'b0, 4'h0, 3'b000);
    tick();
    req_valid_i = 1'b0;
    for (int c = 2; c <= 17; c++) tick();
    pready_i = 1'b1; prdata_i = 32'h7777_1234;
    tick();
    check_val("to_edge_resp", {resp_valid_o, resp_o}, {1'b1, 32'h7777_1234, 1'b0});
    tick();
`else
    // Without the timeout, ACCESS waits as long as pready stays low
    pready_i = 1'b0;
    send(32'h0000_5000, 32'h0, 1'b0, 4'h0, 3'b000);
    tick();
    req_valid_i = 1'b0;
    for (int c = 2; c <= 25; c++) tick();
    check_val("nto_still_access", {psel_o, penable_o, resp_valid_o}, 3'b110);
    pready_i = 1'b1; prdata_i = 32'h7777_1234;
    tick();
    check_val("nto_resp", {resp_valid_o, resp_o}, {1'b1, 32'h7777_1234, 1'b0});
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts one `apb_req_t` transaction, received on a valid/ready request channel, into an AMBA APB3/4 transfer (SETUP then ACCESS).
- Returns the completion as `apb_resp_t` on a valid/ready response channel.
- Sits directly downstream of the transaction producer and upstream of the APB peripheral bus; it is the stage that consumes `apb_req_t` and produces `apb_resp_t`.
- One transfer is outstanding at a time.

Parameters:
- TIMEOUT_CYCLES, 16: ACCESS-phase wait-state limit before forced error completion. Used only when APB_MASTER_TIMEOUT_EN is defined; legal range ≥ 1.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_i  in  72  apb_req_t {addr, wdata, write, strb, prot}.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response ready.
- resp_o  out  33  apb_resp_t {rdata, slverr}.
- paddr_o  out  32  PADDR.
- psel_o  out  1  PSEL.
- penable_o  out  1  PENABLE.
- pwrite_o  out  1  PWRITE.
- pwdata_o  out  32  PWDATA.
- pstrb_o  out  4  PSTRB.
- pprot_o  out  3  PPROT.
- prdata_i  in  32  PRDATA.
- pready_i  in  1  PREADY.
- pslverr_i  in  1  PSLVERR.

Behaviour:
- Reset (async assert, sync deassert) forces:
  - state IDLE
  - all outputs 0 (`req_ready_o` = 1 once in IDLE after reset release)
  - captured request and response registers 0
- Reset mid-transfer abandons the APB transfer immediately: `psel_o`/`penable_o` drop asynchronously.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE:
    - `req_ready_o` = 1.
    - `req_valid_i` && `req_ready_o` captures `req_i` into an internal register → SETUP.
    - Nothing else happens in IDLE.
  - SETUP: `psel_o`=1, `penable_o`=0 → ACCESS unconditionally.
  - ACCESS:
    - `psel_o`=1, `penable_o`=1.
    - `pready_i`=0: stay in ACCESS.
    - `pready_i`=1:
      - capture `resp_o.rdata` = `prdata_i` for reads, 32'h0 for writes.
      - capture `resp_o.slverr` = `pslverr_i`.
      - → RESP.
  - RESP:
    - `resp_valid_o`=1, `psel_o`=`penable_o`=0.
    - `resp_o` holds stable until `resp_valid_o` && `resp_ready_i`, then → IDLE.
- `paddr_o`, `pwrite_o`, `pwdata_o`, `pstrb_o`, `pprot_o` are driven from the captured request register. They are stable from SETUP through the last ACCESS cycle and hold their value in RESP/IDLE.
- `req_ready_o` is a pure decode of state == IDLE; there is no combinational path from any input to `req_ready_o`.
- Latency, with acceptance at cycle 0 and zero wait states:
  - SETUP at cycle 1, ACCESS at cycle 2.
  - `resp_valid_o` at cycle 3.
  - Minimum 4 cycles per transaction including response handshake.
  - Each wait state adds 1 cycle.
- `pstrb_o` is forwarded unchanged on reads. Upstream is responsible for setting it to 0 on reads per APB4.
- `pslverr_i` is sampled only when `pready_i`=1 in ACCESS; it is ignored otherwise.
- Backpressure: `resp_ready_i` held low keeps the FSM in RESP indefinitely. No new request is accepted and the APB bus stays idle.

Optional Feature:
- APB_MASTER_TIMEOUT_EN defined:
  - A wait counter, width $clog2(TIMEOUT_CYCLES+1), clears on entry to ACCESS and increments each ACCESS cycle with `pready_i`=0.
  - On the ACCESS cycle where the counter equals TIMEOUT_CYCLES-1 and `pready_i`=0, the transfer is abandoned → RESP with `slverr`=1, `rdata`=0.
  - `psel_o`/`penable_o` deassert the next cycle.
  - `pready_i`=1 on that same cycle takes priority: normal completion.
- Undefined: no counter; ACCESS waits forever for `pready_i`.

Decomposition:
- Shared package apb_pkg additionally holds:
  - state enum `apb_master_state_e` {IDLE, SETUP, ACCESS, RESP}, 2 bits.
  - constant APB_MASTER_TIMEOUT_DEFAULT = 16.
- Existing `apb_req_t`/`apb_resp_t` and width constants are reused unchanged.
- No sub-module; single FSM module.

Test Plan:
- Write addr=32'h0000_1000, wdata=32'hDEAD_BEEF, strb=4'hF, prot=3'b010, `pready_i` tied 1 → PSEL cycle 1, PENABLE cycle 2, `resp_valid_o` cycle 3 with slverr=0, rdata=0; PADDR/PWDATA stable cycles 1-2.
- Read addr=32'h0000_2004, slave inserts 3 wait states then PRDATA=32'h1234_5678 → `resp_o.rdata`=32'h1234_5678 at cycle 6; `req_ready_o`=0 from cycle 1 until the response handshake.
- Read with `pslverr_i`=1 at completion and `resp_ready_i` held low 5 cycles → `resp_valid_o` and `resp_o` {rdata, slverr=1} stable throughout; `psel_o`=0; second pending request not accepted until the handshake.
- Back-to-back: `req_valid_i` held high for 3 writes, `resp_ready_i`=1, zero wait → accepts at cycles 0, 4, 8; PSEL never high in RESP/IDLE.
- Assert `rst_ni` low during ACCESS with a pending wait → `psel_o`/`penable_o`/`resp_valid_o` go 0 immediately; after release a fresh read completes normally.
- APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, `pready_i` held 0 → `resp_valid_o` exactly 1 cycle after the 16th ACCESS cycle with slverr=1, rdata=0; repeat with `pready_i`=1 on the 16th cycle → normal completion.
